// File: rtl/rca_share_arbiter.sv
// One exact 8-bit ripple-carry adder shared by N_REQ requesters behind a round-robin arbiter.
// Define ARB_FIXED_PRIO_EN to get fixed lowest-index-wins priority and drop the rr_ptr state.

module rca_share_arbiter_rca8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [8:0] sum_o
);
    logic [8:0] carry;
    logic [7:0] bit_sum;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign bit_sum[i]  = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign sum_o = {carry[8], bit_sum};
endmodule

module rca_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [8:0]         res_sum,
    output logic [ID_W-1:0]    res_id,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t            state_q, state_d;
    logic [7:0]        opa_q, opa_d;
    logic [7:0]        opb_q, opb_d;
    logic [8:0]        res_sum_q, res_sum_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
`ifndef ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [7:0]        sel_a;
    logic [7:0]        sel_b;
    logic [8:0]        add_sum;

    rca_share_arbiter_rca8 u_rca (
        .a_i   (opa_q),
        .b_i   (opb_q),
        .sum_o (add_sum)
    );

    // First valid requester found walking upward from the search start, wrapping.
    always_comb begin
        int unsigned idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (32'(rr_ptr_q) + k) % N_REQ;
`endif
            if (!grant_vld && req_valid[ID_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                sel_a = req_a[8*k +: 8];
                sel_b = req_b[8*k +: 8];
                // Grant is withheld while rst is high so no handshake is seen during reset.
                req_ready[k] = (state_q == IDLE) && grant_vld && !rst;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_sum_d = res_sum_q;
        res_id_d  = res_id_q;
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    opa_d    = sel_a;
                    opb_d    = sel_b;
                    res_id_d = grant_idx;
                    state_d  = CALC;
                end
            end
            CALC: begin
                res_sum_d = add_sum;
                state_d   = RESP;
            end
            RESP: begin
                if (res_ready) begin
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr_d = ID_W'((32'(res_id_q) + 1) % N_REQ);
`endif
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            res_sum_q <= '0;
            res_id_q  <= '0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            res_sum_q <= res_sum_d;
            res_id_q  <= res_id_d;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    assign res_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
endmodule

// File: tb/tb_rca_share_arbiter.sv
// Directed bench for rca_share_arbiter (N_REQ=4); expectations are hand-computed sums and grant orders.

module tb_rca_share_arbiter;
    localparam int N = 4;
    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [8:0]     res_sum;
    logic [W-1:0]   res_id;
    logic           busy;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rca_share_arbiter #(.N_REQ(N), .ID_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    // Full transaction with res_ready high: grant now, result two edges later, IDLE after that.
    task automatic do_op(input int g, input logic [8:0] s);
        #1;
        chk("grant", 16'(req_ready), 16'(1 << g));
        tick();
        chk("calc_busy", 16'(busy), 16'h1);
        chk("calc_nv", 16'(res_valid), 16'h0);
        chk("calc_nogrant", 16'(req_ready), 16'h0);
        tick();
        chk("resp_valid", 16'(res_valid), 16'h1);
        chk("resp_sum", 16'(res_sum), 16'(s));
        chk("resp_id", 16'(res_id), 16'(g));
        tick();
        chk("idle_nv", 16'(res_valid), 16'h0);
        chk("idle_busy", 16'(busy), 16'h0);
    endtask

    initial begin
`ifdef ARB_FIXED_PRIO_EN
        int rr_ord[5]   = '{0, 0, 0, 0, 0};
        int wrap_ord[3] = '{0, 0, 0};
`else
        int rr_ord[5]   = '{0, 1, 2, 3, 0};
        int wrap_ord[3] = '{3, 0, 3};
`endif
        logic [8:0] sum_tab[4] = '{9'h100, 9'h100, 9'h0FF, 9'h1FE};

        rst       = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        set_ops(0, 8'h80, 8'h80);
        set_ops(1, 8'hC3, 8'h3D);
        set_ops(2, 8'h5A, 8'hA5);
        set_ops(3, 8'hFF, 8'hFF);

        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_ready", 16'(req_ready), 16'h0);
            chk("rst_valid", 16'(res_valid), 16'h0);
            chk("rst_busy", 16'(busy), 16'h0);
            chk("rst_sum", 16'(res_sum), 16'h0);
            chk("rst_id", 16'(res_id), 16'h0);
        end
        rst = 1'b0;

        // All requesters valid: one grant every three cycles in rotation.
        for (int k = 0; k < 5; k++) do_op(rr_ord[k], sum_tab[rr_ord[k]]);

        req_valid = 4'b0100;
        set_ops(2, 8'hFF, 8'h01);
        do_op(2, 9'h100);

        // Only 3 and 0 requesting, pointer sits at 3.
        req_valid = 4'b1001;
        for (int k = 0; k < 3; k++) do_op(wrap_ord[k], sum_tab[wrap_ord[k]]);

        req_valid = 4'b0010;
        set_ops(1, 8'h7F, 8'h80);
        res_ready = 1'b0;
        #1;
        chk("bp_grant", 16'(req_ready), 16'b0010);
        tick();
        tick();
        chk("bp_valid0", 16'(res_valid), 16'h1);
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid", 16'(res_valid), 16'h1);
            chk("bp_sum", 16'(res_sum), 16'h0FF);
            chk("bp_id", 16'(res_id), 16'h1);
            chk("bp_nogrant", 16'(req_ready), 16'h0);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_release_nv", 16'(res_valid), 16'h0);
        chk("bp_release_busy", 16'(busy), 16'h0);

        req_valid = 4'b0001;
        set_ops(0, 8'h10, 8'h20);
        #1;
        chk("mid_grant", 16'(req_ready), 16'b0001);
        tick();
        chk("mid_calc", 16'(busy), 16'h1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 16'(busy), 16'h0);
        chk("mid_rst_valid", 16'(res_valid), 16'h0);
        chk("mid_rst_sum", 16'(res_sum), 16'h0);
        chk("mid_rst_ready", 16'(req_ready), 16'h0);
        rst       = 1'b0;
        req_valid = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mid_no_valid", 16'(res_valid), 16'h0);
            chk("mid_no_grant", 16'(req_ready), 16'h0);
        end
        set_ops(0, 8'h01, 8'h02);
        req_valid = 4'b0001;
        do_op(0, 9'h003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
